// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    DATA,
    CSUM,
    HOLD
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_TMO
  } err_e;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter; used by uart_frame_ctrl only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter parks at LAST so a late clear can never see a wrapped value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = !i_clear && i_enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames the UART RX byte stream (SYNC CMD LEN PAYLOAD CSUM) into valid/ready commands.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rx_dv,
  input  logic [7:0]             i_rx_byte,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  output logic [7:0]             o_cmd,
  output logic [3:0]             o_len,
  output logic [8*MAX_LEN-1:0]   o_payload,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_busy
);

  if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_frame_ctrl: MAX_LEN must be 1..15 and TIMEOUT_CYCLES >= 2");
  end

  state_e               state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [3:0]           len_q, len_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           csum_q, csum_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  err_e                 err_q, err_d;
  logic                 eval_idle;
  logic                 tmo_expired;

`ifdef UART_FRAME_TIMEOUT_EN
  logic tmo_clear;
  assign tmo_clear = i_rx_dv || (state_q == IDLE) || (state_q == HOLD);

  uart_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (tmo_clear),
    .i_enable  (!tmo_clear),
    .o_expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    payload_d = payload_q;
    ovr_d     = 1'b0;
    err_d     = ERR_NONE;
    eval_idle = 1'b0;

    unique case (state_q)
      IDLE: eval_idle = i_rx_dv;
      CMD: begin
        if (i_rx_dv) begin
          cmd_d   = i_rx_byte;
          csum_d  = i_rx_byte;
          state_d = LEN;
        end else if (tmo_expired) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      LEN: begin
        if (i_rx_dv) begin
          if (i_rx_byte > 8'(MAX_LEN)) begin
            err_d   = ERR_LEN;
            state_d = IDLE;
          end else begin
            len_d   = i_rx_byte[3:0];
            csum_d  = csum_q ^ i_rx_byte;
            idx_d   = '0;
            state_d = (i_rx_byte == 8'd0) ? CSUM : DATA;
          end
        end else if (tmo_expired) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (i_rx_dv) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) payload_d[8*i +: 8] = i_rx_byte;
          end
          csum_d = csum_q ^ i_rx_byte;
          idx_d  = idx_q + 4'd1;
          if (idx_q + 4'd1 == len_q) state_d = CSUM;
        end else if (tmo_expired) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      CSUM: begin
        if (i_rx_dv) begin
          if (i_rx_byte == csum_q) begin
            state_d = HOLD;
          end else begin
            err_d   = ERR_CSUM;
            state_d = IDLE;
          end
        end else if (tmo_expired) begin
          err_d   = ERR_TMO;
          state_d = IDLE;
        end
      end
      HOLD: begin
        // A byte arriving on the accept cycle belongs to the next frame.
        if (i_cmd_ready) begin
          state_d   = IDLE;
          eval_idle = i_rx_dv;
        end else if (i_rx_dv) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eval_idle && (i_rx_byte == SYNC_BYTE)) begin
      state_d   = CMD;
      payload_d = '0;
      idx_d     = '0;
    end

    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the payload store is a handful of flops, so it is reset with everything else; a RAM would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd       = cmd_q;
  assign o_len       = len_q;
  assign o_payload   = payload_q;
  assign o_frame_err = (err_q != ERR_NONE);
  assign o_overrun   = ovr_q;
  assign o_busy      = busy_q;

endmodule
